addsub_pipe: RTL

Parametrised, pipelined two's-complement add/subtract unit, the multi-width successor to the 4-bit combinational subtractor. The carry/borrow chain is split into CHUNK-bit slices with one register stage per slice, so wide operands close timing at one slice per cycle. Operands enter and results leave through valid/ready handshakes. The block sits in the datapath between operand sources and result consumers.

---
 rtl/addsub_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement add/subtract unit.
//
// The carry chain is cut into CHUNK-bit slices, one register stage per slice
// (STAGES = WIDTH / CHUNK). Stage k adds operand bits [k*CHUNK +: CHUNK] with
// the carry registered by stage k-1. Unconsumed upper operand slices and the
// already-completed lower result slices travel forward with each item.
// WIDTH must be a multiple of CHUNK and at least CHUNK.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset; discards all in-flight items
//   in_valid     operands and mode are valid
//   in_ready     block can accept operands this cycle (= global advance)
//   mode         0 = a + b, 1 = a - b
//   a, b         WIDTH-bit operands
//   out_valid    result fields are valid
//   out_ready    consumer accepts the result this cycle
//   result       sum or difference, modulo 2^WIDTH
//   carry_borrow add: carry out of MSB; subtract: borrow (unsigned a < b)
//   overflow     signed two's-complement overflow
//   zero         result == 0
module addsub_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    // Whole pipe moves together; a stalled output freezes every stage.
    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;

    // Final-stage registers (the output stage).
    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_res;
    logic             r_out_cb;
    logic             r_out_ovf;

    assign w_adv   = !r_out_vld || out_ready;
    // Subtraction is a + ~b + 1; the +1 enters as stage 0 carry-in.
    assign w_b_eff = mode ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO  = k * CHUNK;
        localparam int unsigned UPW = WIDTH - LO;

        // Item entering this stage: operand bits still to be added, carry-in,
        // and the result slices completed by earlier stages.
        logic              w_vld;
        logic              w_mode;
        logic              w_cin;
        logic [UPW-1:0]    w_a;
        logic [UPW-1:0]    w_b;
        logic [CHUNK:0]    w_sum;
        logic [LO+CHUNK-1:0] w_res;

        if (k == 0) begin : g_src_in
            assign w_vld  = in_valid;
            assign w_mode = mode;
            assign w_cin  = mode;
            assign w_a    = a;
            assign w_b    = w_b_eff;
            assign w_res  = w_sum[CHUNK-1:0];
        end else begin : g_src_prev
            assign w_vld  = g_stage[k-1].g_mid.r_vld;
            assign w_mode = g_stage[k-1].g_mid.r_mode;
            assign w_cin  = g_stage[k-1].g_mid.r_cy;
            assign w_a    = g_stage[k-1].g_mid.r_a;
            assign w_b    = g_stage[k-1].g_mid.r_b;
            assign w_res  = {w_sum[CHUNK-1:0], g_stage[k-1].g_mid.r_res};
        end

        assign w_sum = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, w_cin};

        if (k < STAGES - 1) begin : g_mid
            logic                  r_vld;
            logic                  r_mode;
            logic                  r_cy;
            logic [UPW-CHUNK-1:0]  r_a;
            logic [UPW-CHUNK-1:0]  r_b;
            logic [LO+CHUNK-1:0]   r_res;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld  <= 1'b0;
                    r_mode <= 1'b0;
                    r_cy   <= 1'b0;
                    r_a    <= '0;
                    r_b    <= '0;
                    r_res  <= '0;
                end else if (w_adv) begin
                    r_vld  <= w_vld;
                    r_mode <= w_mode;
                    r_cy   <= w_sum[CHUNK];
                    r_a    <= w_a[UPW-1:CHUNK];
                    r_b    <= w_b[UPW-1:CHUNK];
                    r_res  <= w_res;
                end
            end
        end else begin : g_last
            // Here w_a/w_b hold exactly the top slice, so bit CHUNK-1 is the
            // operand MSB. With b already inverted for subtract, both modes
            // reduce to: equal operand signs and a result sign that differs.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_vld <= 1'b0;
                    r_out_res <= '0;
                    r_out_cb  <= 1'b0;
                    r_out_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_out_vld <= w_vld;
                    r_out_res <= w_res;
                    r_out_cb  <= w_sum[CHUNK] ^ w_mode;
                    r_out_ovf <= (w_a[CHUNK-1] == w_b[CHUNK-1])
                              && (w_sum[CHUNK-1] != w_a[CHUNK-1]);
                end
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_out_vld;

    // Bubbles carry stale data; present zeros whenever nothing is valid.
    assign result       = r_out_vld ? r_out_res : '0;
    assign carry_borrow = r_out_vld & r_out_cb;
    assign overflow     = r_out_vld & r_out_ovf;
    assign zero         = r_out_vld & (r_out_res == '0);

endmodule
